// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter: FSM states, requester
// indices and default burst geometry.
package mem_bus_arbiter_pkg;

   localparam int DEF_BURST_WORDS = 4;
   localparam int DEF_BEAT_W      = 2;

   // Bit positions in the request/grant vectors
   localparam int REQ_IC = 0;
   localparam int REQ_DC = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GNT_IC = 2'd1,
      ST_GNT_DC = 2'd2
   } state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter_2.sv
// Combinational 2-way round-robin pick: masked requests in, one-hot grant out.
// On a tie the requester not served last wins.
module rr_arbiter_2
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_dc,
   input  logic [1:0] i_mask,
   output logic [1:0] o_gnt
);

   logic [1:0] w_elig;

   assign w_elig = i_req & ~i_mask;

   always_comb begin
      o_gnt = w_elig;
      if (&w_elig) begin
         o_gnt = '0;
         if (i_last_dc) o_gnt[REQ_IC] = 1'b1;
         else           o_gnt[REQ_DC] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one backing-memory port between I-cache refill and D-cache
// refill/writeback; one line burst per grant, round-robin with a one-cycle gap.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int BURST_WORDS = DEF_BURST_WORDS,
   parameter int BEAT_W      = DEF_BEAT_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ic_req_i,
   input  logic [29:0]       ic_addr_i,
   output logic [31:0]       ic_rdata_o,
   output logic              ic_rvalid_o,
   output logic              ic_done_o,
   input  logic              dc_req_i,
   input  logic              dc_we_i,
   input  logic [29:0]       dc_addr_i,
   input  logic [31:0]       dc_wdata_i,
   output logic              dc_wready_o,
   output logic [31:0]       dc_rdata_o,
   output logic              dc_rvalid_o,
   output logic              dc_done_o,
   output logic [BEAT_W-1:0] beat_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [29:0]       mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [31:0]       mem_rdata_i
);

   state_t             r_state;
   logic [BEAT_W-1:0]  r_beat;
   logic               r_last_dc;
   logic [1:0]         r_mask;
   logic [29-BEAT_W:0] r_base_hi;
   logic               r_we;
   logic               r_mem_req;

   logic [1:0]         w_gnt;
   logic               w_last_beat;
   logic               w_gnt_ic;
   logic               w_gnt_dc;
   logic               w_unused;

   // Line-offset bits of the request address are replaced by the beat counter
   assign w_unused = ^{ic_addr_i[BEAT_W-1:0], dc_addr_i[BEAT_W-1:0]};

   rr_arbiter_2 u_rr (
      .i_req     ({dc_req_i, ic_req_i}),
      .i_last_dc (r_last_dc),
      .i_mask    (r_mask),
      .o_gnt     (w_gnt)
   );

   assign w_last_beat = (r_beat == BEAT_W'(BURST_WORDS - 1));
   assign w_gnt_ic    = (r_state == ST_GNT_IC);
   assign w_gnt_dc    = (r_state == ST_GNT_DC);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= ST_IDLE;
         r_beat    <= '0;
         r_last_dc <= 1'b0;
         r_mask    <= '0;
         r_base_hi <= '0;
         r_we      <= 1'b0;
         r_mem_req <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // The mask only lives for the single IDLE cycle after a done
               r_mask <= '0;
               r_beat <= '0;
               if (w_gnt[REQ_DC]) begin
                  r_state   <= ST_GNT_DC;
                  r_base_hi <= dc_addr_i[29:BEAT_W];
                  r_we      <= dc_we_i;
                  r_last_dc <= 1'b1;
                  r_mem_req <= 1'b1;
               end else if (w_gnt[REQ_IC]) begin
                  r_state   <= ST_GNT_IC;
                  r_base_hi <= ic_addr_i[29:BEAT_W];
                  r_we      <= 1'b0;
                  r_last_dc <= 1'b0;
                  r_mem_req <= 1'b1;
               end
            end
            ST_GNT_IC, ST_GNT_DC: begin
               if (mem_ready_i) begin
                  r_beat <= r_beat + BEAT_W'(1);
                  if (w_last_beat) begin
                     r_state   <= ST_IDLE;
                     r_mem_req <= 1'b0;
                     r_mask    <= w_gnt_dc ? 2'b10 : 2'b01;
                  end
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign beat_o      = r_beat;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = {r_base_hi, r_beat};
   assign mem_wdata_o = dc_wdata_i;

   assign ic_rdata_o  = mem_rdata_i;
   assign dc_rdata_o  = mem_rdata_i;
   assign ic_rvalid_o = mem_ready_i & w_gnt_ic;
   assign dc_rvalid_o = mem_ready_i & w_gnt_dc & ~r_we;
   assign dc_wready_o = mem_ready_i & w_gnt_dc & r_we;
   assign ic_done_o   = mem_ready_i & w_gnt_ic & w_last_beat;
   assign dc_done_o   = mem_ready_i & w_gnt_dc & w_last_beat;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected beat events,
// a negedge monitor pops and compares whenever a beat completes.
module tb_mem_bus_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        ic_req_i = 1'b0;
   logic [29:0] ic_addr_i = '0;
   logic [31:0] ic_rdata_o;
   logic        ic_rvalid_o, ic_done_o;
   logic        dc_req_i = 1'b0;
   logic        dc_we_i = 1'b0;
   logic [29:0] dc_addr_i = '0;
   logic [31:0] dc_wdata_i = '0;
   logic        dc_wready_o;
   logic [31:0] dc_rdata_o;
   logic        dc_rvalid_o, dc_done_o;
   logic [1:0]  beat_o;
   logic        mem_req_o, mem_we_o;
   logic [29:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ready_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   typedef struct packed {
      logic        ic_rv;
      logic        dc_rv;
      logic        dc_wr;
      logic        ic_dn;
      logic        dc_dn;
      logic [1:0]  beat;
      logic [29:0] addr;
      logic        we;
      logic [31:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   mem_bus_arbiter #(.BURST_WORDS(4), .BEAT_W(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdata_o(ic_rdata_o),
      .ic_rvalid_o(ic_rvalid_o), .ic_done_o(ic_done_o),
      .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
      .dc_wdata_i(dc_wdata_i), .dc_wready_o(dc_wready_o), .dc_rdata_o(dc_rdata_o),
      .dc_rvalid_o(dc_rvalid_o), .dc_done_o(dc_done_o), .beat_o(beat_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One completed read beat; ic selects which requester should see it
   task automatic rd_beat(input logic ic, input logic [1:0] b, input logic [29:0] a,
                          input logic [31:0] d);
      ev_t e;
      e = '{ic_rv: ic, dc_rv: !ic, dc_wr: 1'b0, ic_dn: ic && (b == 2'd3),
            dc_dn: !ic && (b == 2'd3), beat: b, addr: a, we: 1'b0, data: d};
      exp_q.push_back(e);
      mem_rdata_i = d;
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
   endtask

   task automatic wr_beat(input logic [1:0] b, input logic [29:0] a, input logic [31:0] d);
      ev_t e;
      e = '{ic_rv: 1'b0, dc_rv: 1'b0, dc_wr: 1'b1, ic_dn: 1'b0,
            dc_dn: (b == 2'd3), beat: b, addr: a, we: 1'b1, data: d};
      exp_q.push_back(e);
      dc_wdata_i  = d;
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
   endtask

   // Monitor: every beat completion must match the head of the scoreboard
   always @(negedge clk_i) begin
      if (rst_i && (ic_rvalid_o || dc_rvalid_o || dc_wready_o || ic_done_o || dc_done_o)) begin
         ev_t act;
         act = '{ic_rv: ic_rvalid_o, dc_rv: dc_rvalid_o, dc_wr: dc_wready_o,
                 ic_dn: ic_done_o, dc_dn: dc_done_o, beat: beat_o, addr: mem_addr_o,
                 we: mem_we_o,
                 data: dc_wready_o ? mem_wdata_o : (ic_rvalid_o ? ic_rdata_o : dc_rdata_o)};
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 72'(act), 72'(0));
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("beat", 72'(act), 72'(e));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #2;
      chk("rst_req", 72'(mem_req_o), 72'(0));
      chk("rst_addr", 72'(mem_addr_o), 72'(0));
      chk("rst_we_beat", 72'({mem_we_o, beat_o}), 72'(0));
      tick();
      rst_i = 1'b1;
      tick();

      // IC only, line 0x40..0x43
      ic_req_i = 1'b1; ic_addr_i = 30'h43;
      tick();
      chk("ic_grant", 72'({mem_req_o, mem_we_o, mem_addr_o}), 72'({1'b1, 1'b0, 30'h40}));
      for (int i = 0; i < 4; i++) rd_beat(1'b1, 2'(i), 30'h40 + 30'(i), 32'hA000_0000 + 32'(i));
      ic_req_i = 1'b0;
      chk("ic_req_drop", 72'(mem_req_o), 72'(0));
      tick();

      // Ready pulses while IDLE do nothing
      mem_ready_i = 1'b1;
      tick();
      chk("idle_outs", 72'({ic_rvalid_o, dc_rvalid_o, dc_wready_o, ic_done_o, dc_done_o}), 72'(0));
      tick();
      chk("idle_beat", 72'({mem_req_o, beat_o}), 72'(0));
      mem_ready_i = 1'b0;

      // Tie: DC first (last served IC), gap, then IC
      ic_req_i = 1'b1; ic_addr_i = 30'h100;
      dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 30'h205;
      tick();
      chk("tie1_dc", 72'({mem_req_o, mem_addr_o}), 72'({1'b1, 30'h204}));
      for (int i = 0; i < 4; i++) rd_beat(1'b0, 2'(i), 30'h204 + 30'(i), 32'hB000_0000 + 32'(i));
      dc_req_i = 1'b0;
      chk("tie1_gap", 72'(mem_req_o), 72'(0));
      tick();
      chk("tie1_ic", 72'({mem_req_o, mem_addr_o}), 72'({1'b1, 30'h100}));
      for (int i = 0; i < 4; i++) rd_beat(1'b1, 2'(i), 30'h100 + 30'(i), 32'hC000_0000 + 32'(i));
      ic_req_i = 1'b0;
      tick();
      tick();

      // Second tie goes to DC again: writeback with stall pattern 1,0,0,1,1,0,1
      ic_req_i = 1'b1; ic_addr_i = 30'h8A;
      dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 30'h3F0;
      tick();
      chk("tie2_dc_we", 72'({mem_req_o, mem_we_o, mem_addr_o}), 72'({1'b1, 1'b1, 30'h3F0}));
      dc_we_i = 1'b0; dc_addr_i = 30'h777;
      wr_beat(2'd0, 30'h3F0, 32'hD000_0000);
      tick();
      tick();
      chk("wr_stall", 72'({mem_req_o, mem_we_o, beat_o, mem_addr_o}),
          72'({1'b1, 1'b1, 2'd1, 30'h3F1}));
      wr_beat(2'd1, 30'h3F1, 32'hD000_0001);
      wr_beat(2'd2, 30'h3F2, 32'hD000_0002);
      tick();
      wr_beat(2'd3, 30'h3F3, 32'hD000_0003);
      dc_req_i = 1'b0;

      // IC was waiting: granted on the gap edge since only DC is masked
      tick();
      chk("ic_after_wb", 72'({mem_req_o, mem_we_o, mem_addr_o}), 72'({1'b1, 1'b0, 30'h88}));
      for (int i = 0; i < 4; i++) rd_beat(1'b1, 2'(i), 30'h88 + 30'(i), 32'hE000_0000 + 32'(i));

      // IC holds req past done: not re-served on the gap cycle, re-served after
      chk("hold_idle", 72'(mem_req_o), 72'(0));
      tick();
      chk("hold_gap", 72'(mem_req_o), 72'(0));
      tick();
      chk("hold_regrant", 72'({mem_req_o, mem_addr_o}), 72'({1'b1, 30'h88}));
      for (int i = 0; i < 4; i++) rd_beat(1'b1, 2'(i), 30'h88 + 30'(i), 32'hF000_0000 + 32'(i));
      ic_req_i = 1'b0;
      tick();

      // Async reset mid-burst at beat 2
      dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 30'h500;
      tick();
      rd_beat(1'b0, 2'd0, 30'h500, 32'h1234_0000);
      rd_beat(1'b0, 2'd1, 30'h501, 32'h1234_0001);
      chk("pre_rst_beat", 72'({mem_req_o, beat_o}), 72'({1'b1, 2'd2}));
      #2;
      rst_i = 1'b0;
      #1;
      chk("async_rst", 72'({mem_req_o, mem_we_o, beat_o, mem_addr_o}), 72'(0));
      dc_req_i = 1'b0;
      tick();
      rst_i = 1'b1;
      tick();
      ic_req_i = 1'b1; ic_addr_i = 30'h600;
      tick();
      chk("post_rst_ic", 72'({mem_req_o, beat_o, mem_addr_o}), 72'({1'b1, 2'd0, 30'h600}));
      for (int i = 0; i < 4; i++) rd_beat(1'b1, 2'(i), 30'h600 + 30'(i), 32'h5555_0000 + 32'(i));
      ic_req_i = 1'b0;
      tick();
      tick();

      chk("queue_drained", 72'(exp_q.size()), 72'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
